// File: rtl/subckt_stim_driver_pkg.sv
// subckt_tb_pkg: shared types and constants for the subcircuit stimulus driver.
//   state_t        driver FSM states
//   LFSR_TAPS      feedback taps (bits 15, 13, 12, 10)
//   SEED_DEFAULT   reset value of the seed register
//   SEED_NONZERO   stored in place of an all-zero seed so the LFSR cannot lock up
//   lfsr_step      one shift of a tapped register with a serial injection bit
package subckt_tb_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } state_t;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] SEED_DEFAULT = 16'hACE1;
    localparam logic [15:0] SEED_NONZERO = 16'h0001;
    function automatic logic [15:0] lfsr_step(input logic [15:0] q, input logic inj);
        return {q[14:0], ^(q & LFSR_TAPS) ^ inj};
    endfunction
endpackage

// File: rtl/subckt_stim_driver_if.sv
// subckt_stim_driver_if: control, stimulus and response bundle of the stimulus driver.
//   start/seed_load/seed  run control from the test flow
//   resp                  subcircuit output
//   stim/stim_valid       vector driven into the subcircuit
//   busy/done             run status
//   signature/vec_count   compacted response and progress
// master is the driver itself; slave is the surrounding flow and subcircuit.
interface subckt_stim_driver_if #(
    parameter int VEC_W = 5
);
    logic             start;
    logic             seed_load;
    logic [15:0]      seed;
    logic             resp;
    logic [VEC_W-1:0] stim;
    logic             stim_valid;
    logic             busy;
    logic             done;
    logic [15:0]      signature;
    logic [15:0]      vec_count;
    modport master (
        input  start, seed_load, seed, resp,
        output stim, stim_valid, busy, done, signature, vec_count
    );
    modport slave (
        output start, seed_load, seed, resp,
        input  stim, stim_valid, busy, done, signature, vec_count
    );
endinterface

// File: rtl/subckt_stim_driver_lfsr.sv
// subckt_lfsr16: 16-bit tapped shift register with serial injection, load and enable.
//   clk       clock
//   rst_n     synchronous active-low reset, clears q
//   load      load load_val (wins over en)
//   load_val  value for load
//   en        shift one step, feeding back taps xor inj
//   inj       serial injection bit (0 for a plain LFSR, response bit for a signature)
//   q         register contents
module subckt_lfsr16
    import subckt_tb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        en,
    input  logic        inj,
    output logic [15:0] q
);
    always_ff @(posedge clk) begin
        if (!rst_n)
            q <= '0;
        else if (load)
            q <= load_val;
        else if (en)
            q <= lfsr_step(q, inj);
    end
endmodule

// File: rtl/subckt_stim_driver.sv
// subckt_stim_driver: drives LFSR vectors into a subcircuit and compacts its output into a signature.
//   I1470_clk  clock
//   I1477_rst  synchronous active-low reset
//   bus        subckt_stim_driver_if.master: start/seed_load/seed/resp in,
//              stim/stim_valid/busy/done/signature/vec_count out
// Each vector runs APPLY (1) -> SETTLE (SETTLE cycles) -> CAPTURE (1); after
// N_VEC captures the driver parks in DONE holding signature and vec_count.
module subckt_stim_driver
    import subckt_tb_pkg::*;
#(
    parameter int          VEC_W  = 5,
    parameter int          N_VEC  = 1000,
    parameter int          SETTLE = 3,
    parameter logic [15:0] SEED   = SEED_DEFAULT
) (
    input logic                   I1470_clk,
    input logic                   I1477_rst,
    subckt_stim_driver_if.master  bus
);
    state_t      state;
    logic [15:0] seed_reg;
    logic [15:0] seed_eff;
    logic [15:0] seed_use;
    logic [15:0] lfsr_q;
    logic [15:0] vec_next;
    logic [7:0]  settle_cnt;
    logic        launch;
    logic        capture;
    always_comb begin
        seed_eff = bus.seed == 16'h0000 ? SEED_NONZERO : bus.seed;
        // a seed loaded together with start is used by that start
        seed_use = bus.seed_load ? seed_eff : seed_reg;
        launch   = (state == ST_IDLE || state == ST_DONE) && bus.start;
        capture  = state == ST_CAPTURE;
        vec_next = bus.vec_count + 16'd1;
    end
    subckt_lfsr16 u_lfsr (
        .clk      (I1470_clk),
        .rst_n    (I1477_rst),
        .load     (launch),
        .load_val (seed_use),
        .en       (capture),
        .inj      (1'b0),
        .q        (lfsr_q)
    );
    subckt_lfsr16 u_sig (
        .clk      (I1470_clk),
        .rst_n    (I1477_rst),
        .load     (launch),
        .load_val (16'h0000),
        .en       (capture),
        .inj      (bus.resp),
        .q        (bus.signature)
    );
    always_ff @(posedge I1470_clk) begin
        if (!I1477_rst) begin
            state          <= ST_IDLE;
            seed_reg       <= SEED;
            settle_cnt     <= '0;
            bus.stim       <= '0;
            bus.stim_valid <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.vec_count  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.seed_load)
                        seed_reg <= seed_eff;
                    if (bus.start) begin
                        state          <= ST_APPLY;
                        bus.stim       <= seed_use[VEC_W-1:0];
                        bus.stim_valid <= 1'b1;
                        bus.busy       <= 1'b1;
                        bus.done       <= 1'b0;
                        bus.vec_count  <= '0;
                    end
                end
                ST_APPLY: begin
                    settle_cnt <= '0;
                    state      <= SETTLE > 0 ? ST_SETTLE : ST_CAPTURE;
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt + 8'd1;
                    if (settle_cnt == 8'(SETTLE - 1))
                        state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    bus.vec_count <= vec_next;
                    if (vec_next == 16'(N_VEC)) begin
                        state          <= ST_DONE;
                        bus.stim_valid <= 1'b0;
                        bus.busy       <= 1'b0;
                        bus.done       <= 1'b1;
                    end else begin
                        state    <= ST_APPLY;
                        // low bits of the LFSR value after this capture's shift
                        bus.stim <= {lfsr_q[VEC_W-2:0], ^(lfsr_q & LFSR_TAPS)};
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_subckt_stim_driver.sv
// tb_subckt_stim_driver: drives two driver instances (N_VEC=2/SETTLE=0 and
// N_VEC=3/SETTLE=2) and compares every output on every cycle with a run-level
// reference model, plus directed checks of known signatures and timing.
module tb_subckt_stim_driver;
    localparam logic [15:0] TAP = 16'hB400;
    typedef struct packed {
        logic [4:0]  stim;
        logic        valid;
        logic        busy;
        logic        done;
        logic [15:0] sig;
        logic [15:0] vc;
    } snap_t;
    logic        clk = 1'b0;
    logic        rst;
    logic        st [2];
    logic        sl [2];
    logic [15:0] sd [2];
    logic        resp;
    logic        rv [0:1023];
    int          cyc;
    int          total;
    int          bad;
    int          ka [2];
    logic        md [2];
    logic [15:0] sa [2];
    logic [15:0] sr [2];
    logic        eb [2];
    int          nb;
    always #5 clk = ~clk;
    subckt_stim_driver_if #(.VEC_W(5)) ifa ();
    subckt_stim_driver_if #(.VEC_W(5)) ifb ();
    assign ifa.start     = st[0];
    assign ifa.seed_load = sl[0];
    assign ifa.seed      = sd[0];
    assign ifa.resp      = resp;
    assign ifb.start     = st[1];
    assign ifb.seed_load = sl[1];
    assign ifb.seed      = sd[1];
    assign ifb.resp      = resp;
    subckt_stim_driver #(.VEC_W(5), .N_VEC(2), .SETTLE(0), .SEED(16'hACE1)) dut_a (
        .I1470_clk (clk),
        .I1477_rst (rst),
        .bus       (ifa.master)
    );
    subckt_stim_driver #(.VEC_W(5), .N_VEC(3), .SETTLE(2), .SEED(16'hACE1)) dut_b (
        .I1470_clk (clk),
        .I1477_rst (rst),
        .bus       (ifb.master)
    );
    // Expected outputs of instance d, t cycles after its run's start edge.
    // Vector v's response is whatever resp held just before its closing edge.
    function automatic snap_t model(input int d);
        snap_t       e;
        int          n;
        int          p;
        int          t;
        int          cur;
        logic        fin;
        logic [15:0] x;
        logic [15:0] s;
        e = '0;
        if (!md[d])
            return e;
        n   = d ? 3 : 2;
        p   = d ? 4 : 2;
        t   = cyc - ka[d];
        fin = t >= n * p;
        cur = fin ? n : t / p;
        x   = sa[d];
        s   = 16'h0000;
        for (int v = 0; v < cur; v++)
            s = {s[14:0], ^(s & TAP) ^ rv[ka[d] + v * p + p - 1]};
        for (int v = 0; v < (fin ? n - 1 : cur); v++)
            x = {x[14:0], ^(x & TAP)};
        e.stim  = x[4:0];
        e.valid = !fin;
        e.busy  = !fin;
        e.done  = fin;
        e.sig   = s;
        e.vc    = 16'(cur);
        return e;
    endfunction
    function automatic snap_t observe(input int d);
        return d == 0 ? snap_t'({ifa.stim, ifa.stim_valid, ifa.busy, ifa.done, ifa.signature, ifa.vec_count})
                      : snap_t'({ifb.stim, ifb.stim_valid, ifb.busy, ifb.done, ifb.signature, ifb.vec_count});
    endfunction
    task automatic chk(input string tag, input int d, input snap_t o, input snap_t e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s dut%0d cyc=%0d observed=%h expected=%h", tag, d, cyc, o, e);
        end
    endtask
    task automatic chk16(input string tag, input logic [15:0] o, input logic [15:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, o, e);
        end
    endtask
    // One clock: update the model from the inputs seen at this edge, then
    // compare both instances against it.
    task automatic tick();
        snap_t e;
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                md[d] = 1'b0;
                sr[d] = 16'hACE1;
            end else if (!eb[d]) begin
                if (sl[d])
                    sr[d] = sd[d] == 16'h0000 ? 16'h0001 : sd[d];
                if (st[d]) begin
                    md[d] = 1'b1;
                    ka[d] = cyc;
                    sa[d] = sr[d];
                end
            end
        end
        #1;
        resp = rv[cyc];
        for (int d = 0; d < 2; d++) begin
            e = model(d);
            chk("cycle", d, observe(d), e);
            eb[d] = e.busy;
        end
    endtask
    task automatic set_rv(input logic v);
        for (int i = cyc; i < cyc + 41; i++)
            rv[i] = v;
        resp = v;
    endtask
    task automatic start_both(input logic load, input logic [15:0] s0, input logic [15:0] s1);
        sd[0] = s0;
        sd[1] = s1;
        sl[0] = load;
        sl[1] = load;
        st[0] = 1'b1;
        st[1] = 1'b1;
        tick();
        st[0] = 1'b0;
        st[1] = 1'b0;
        sl[0] = 1'b0;
        sl[1] = 1'b0;
    endtask
    initial begin
        for (int i = 0; i < 1024; i++)
            rv[i] = 1'($urandom_range(0, 1));
        total = 0;
        bad   = 0;
        cyc   = 0;
        nb    = 0;
        rst   = 1'b0;
        resp  = 1'b0;
        for (int d = 0; d < 2; d++) begin
            st[d] = 1'b0;
            sl[d] = 1'b0;
            sd[d] = 16'h0000;
            md[d] = 1'b0;
            sr[d] = 16'hACE1;
            eb[d] = 1'b0;
            ka[d] = 0;
            sa[d] = 16'h0000;
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
        // seed 1, resp held at 1
        set_rv(1'b1);
        start_both(1'b1, 16'h0001, 16'h0001);
        nb = int'(ifb.busy);
        chk16("a_first_stim", {11'd0, ifa.stim}, 16'h0001);
        repeat (2) begin
            tick();
            nb += int'(ifb.busy);
        end
        chk16("a_second_stim", {11'd0, ifa.stim}, 16'h0002);
        chk16("a_sig_after_one", ifa.signature, 16'h0001);
        tick();
        nb += int'(ifb.busy);
        chk16("a_done_not_yet", {15'd0, ifa.done}, 16'h0000);
        tick();
        nb += int'(ifb.busy);
        chk16("a_done_k5", {15'd0, ifa.done}, 16'h0001);
        chk16("a_sig_resp1", ifa.signature, 16'h0003);
        chk16("a_vc", ifa.vec_count, 16'd2);
        repeat (9) begin
            tick();
            nb += int'(ifb.busy);
        end
        chk16("b_busy_cycles", 16'(nb), 16'd12);
        chk16("b_sig_resp1", ifb.signature, 16'h0007);
        chk16("b_done", {15'd0, ifb.done}, 16'h0001);
        // same seed register, resp held at 0
        set_rv(1'b0);
        start_both(1'b0, 16'h0000, 16'h0000);
        repeat (13) tick();
        chk16("a_sig_resp0", ifa.signature, 16'h0000);
        chk16("a_done_resp0", {15'd0, ifa.done}, 16'h0001);
        chk16("a_vc_resp0", ifa.vec_count, 16'd2);
        // zero seed is stored as 1
        sd[0] = 16'h5A5A;
        sl[0] = 1'b1;
        tick();
        sd[0] = 16'h0000;
        tick();
        sl[0] = 1'b0;
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        chk16("a_zero_seed_stim", {11'd0, ifa.stim}, 16'h0001);
        repeat (5) tick();
        // random seeds and responses
        repeat (6) begin
            start_both(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
            repeat (13) tick();
        end
        // reset during SETTLE of the second vector
        start_both(1'b0, 16'h0000, 16'h0000);
        repeat (5) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk16("b_rst_sig", ifb.signature, 16'h0000);
        chk16("b_rst_flags", {11'd0, ifb.stim_valid, ifb.busy, ifb.done, 2'd0}, 16'h0000);
        chk16("b_rst_stim", {11'd0, ifb.stim}, 16'h0000);
        st[1] = 1'b1;
        tick();
        st[1] = 1'b0;
        chk16("b_stim_seed_default", {11'd0, ifb.stim}, 16'h0001);
        repeat (13) tick();
        chk16("b_done_after_rst", {15'd0, ifb.done}, 16'h0001);
        // start/seed_load while busy are ignored; start in DONE restarts
        st[1] = 1'b1;
        tick();
        st[1] = 1'b0;
        repeat (3) tick();
        st[1] = 1'b1;
        sl[1] = 1'b1;
        sd[1] = 16'($urandom) | 16'h0100;
        repeat (4) tick();
        st[1] = 1'b0;
        sl[1] = 1'b0;
        repeat (6) tick();
        chk16("b_done_ignored", {15'd0, ifb.done}, 16'h0001);
        st[1] = 1'b1;
        tick();
        st[1] = 1'b0;
        chk16("b_restart_sig", ifb.signature, 16'h0000);
        chk16("b_restart_vc", ifb.vec_count, 16'h0000);
        repeat (13) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
